// File: rtl/npc_pkg.sv
//============================================================================
// Module      : npc_pkg
// Description : Shared widths, reset constants and fetch-state encoding.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package npc_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_WAIT = 2'd2,
        FETCH_HOLD = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/ifu_pc_reg.sv
//============================================================================
// Module      : ifu_pc_reg
// Description : Word-aligned program counter with redirect load and +4 step.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ifu_pc_reg
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc
);

    localparam logic [XLEN-1:0] c_pc_align_mask = ~32'd3;
    localparam logic [XLEN-1:0] c_pc_step       = 32'd4;

    logic [XLEN-1:0] r_pc;

    // Load beats increment so a redirect always wins over the fall-through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC & c_pc_align_mask;
        end else if (i_load) begin
            r_pc <= i_load_pc & c_pc_align_mask;
        end else if (i_inc) begin
            r_pc <= r_pc + c_pc_step;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
//============================================================================
// Module      : ifu_fetch
// Description : Single-outstanding instruction fetch with redirect squash and
//               a one-entry output register towards decode.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic            r_drop;
    logic            w_drop_next;
    logic            w_accept;
    logic            w_capture;
    logic            w_release;
    logic [XLEN-1:0] w_pc;
    logic            r_inst_valid;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;

    ifu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (redirect_valid),
        .i_load_pc (redirect_pc),
        .i_inc     (w_capture),
        .o_pc      (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH_IDLE;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
        end
    end

    // drop marks a fetch already accepted by memory whose data must be thrown away.
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        case (r_state)
            FETCH_IDLE: begin
                w_state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (imem_req_ready) begin
                    w_state_next = FETCH_WAIT;
                    w_drop_next  = redirect_valid;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    w_drop_next  = 1'b0;
                    w_state_next = (r_drop || redirect_valid) ? FETCH_REQ : FETCH_HOLD;
                end else if (redirect_valid) begin
                    w_drop_next = 1'b1;
                end
            end
            FETCH_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    w_state_next = FETCH_REQ;
                end
            end
            default: begin
                w_state_next = FETCH_IDLE;
                w_drop_next  = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_accept  = (r_state == FETCH_REQ) && imem_req_ready;
        w_capture = (r_state == FETCH_WAIT) && imem_rsp_valid && !r_drop && !redirect_valid;
        w_release = (r_state == FETCH_HOLD) && (inst_ready || redirect_valid);
        imem_req_valid = (r_state == FETCH_REQ);
        imem_req_addr  = w_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
        end else if (w_capture) begin
            r_inst_valid <= 1'b1;
            r_inst       <= imem_rsp_data;
            r_inst_pc    <= w_pc;
        end else if (w_release) begin
            r_inst_valid <= 1'b0;
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;

    // Accept is only observed through the state transition; kept for readability of waves.
    logic w_unused;
    assign w_unused = w_accept;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
//============================================================================
// Module      : tb_ifu_fetch
// Description : Scoreboard bench for ifu_fetch with a latency-programmable
//               instruction memory and an address-level fetch model.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ifu_fetch;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int  mem_lat  = 1;
    bit  mem_rand = 1'b0;

    // Reference model state: where the next fetch must go and what decode must see.
    logic [31:0] exp_pc = RESET_PC_DEFAULT;
    bit          outst  = 1'b0;
    bit          cancel = 1'b0;
    logic [31:0] outst_addr = '0;
    logic [63:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] cons_pc[$];
    int          cons_cyc[$];
    bit          prev_hold = 1'b0;
    logic [31:0] prev_inst = '0;
    logic [31:0] prev_pc = '0;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout, got no event expected one (t=%0t)", name, $time);
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i >= 0 && acc_log.size() > i) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] last_cons_pc();
        return (cons_pc.size() > 0) ? cons_pc[cons_pc.size()-1] : 32'hDEAD_BEEF;
    endfunction

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                exp_pc    = RESET_PC_DEFAULT;
                outst     = 1'b0;
                cancel    = 1'b0;
                prev_hold = 1'b0;
                exp_q.delete();
            end else begin
                cyc++;
                check("inst_valid_vs_model", 32'(inst_valid), 32'(exp_q.size() != 0));
                if (inst_valid) check("req_while_holding", 32'(imem_req_valid), 32'd0);
                if (prev_hold && inst_valid) begin
                    check("held_inst", inst, prev_inst);
                    check("held_inst_pc", inst_pc, prev_pc);
                end
                if (imem_rsp_valid && outst) begin
                    if (!cancel && !redirect_valid) begin
                        exp_q.push_back({memf(outst_addr), outst_addr});
                        exp_pc = outst_addr + 32'd4;
                    end
                    outst = 1'b0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    check("req_addr", imem_req_addr, exp_pc);
                    acc_log.push_back(imem_req_addr);
                    outst      = 1'b1;
                    cancel     = 1'b0;
                    outst_addr = exp_pc;
                end
                if (inst_valid && inst_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_inst_pc", inst_pc, 32'hFFFF_FFFF);
                    end else begin
                        logic [63:0] e;
                        e = exp_q.pop_front();
                        check("inst_data", inst, e[63:32]);
                        check("inst_pc", inst_pc, e[31:0]);
                        cons_pc.push_back(e[31:0]);
                        cons_cyc.push_back(cyc);
                    end
                end
                if (redirect_valid) begin
                    exp_pc = redirect_pc & ~32'd3;
                    if (outst) cancel = 1'b1;
                    exp_q.delete();
                end
                prev_hold = inst_valid && !inst_ready && !redirect_valid;
                prev_inst = inst;
                prev_pc   = inst_pc;
            end
        end
    end

    // Instruction memory: one outstanding fetch, response mem_lat cycles after accept.
    initial begin
        bit          acc;
        bit          busy;
        int          cnt;
        logic [31:0] acc_a;
        logic [31:0] raddr;
        busy  = 1'b0;
        cnt   = 0;
        raddr = '0;
        forever begin
            @(negedge clk);
            acc   = imem_req_valid && imem_req_ready;
            acc_a = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (acc) begin
                busy  = 1'b1;
                cnt   = mem_lat;
                raddr = acc_a;
            end
            if (busy) begin
                if (cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memf(raddr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            imem_req_ready = !busy && (!mem_rand || ($urandom_range(0, 1) == 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req_valid && imem_req_ready) && n < 200);
        if (!(imem_req_valid && imem_req_ready)) fail_timeout(name);
    endtask

    task automatic wait_inst_valid(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inst_valid && n < 200);
        if (!inst_valid) fail_timeout(name);
    endtask

    task automatic wait_cons(input int k, input string name);
        int base = cons_cyc.size();
        int n = 0;
        while (cons_cyc.size() < base + k && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (cons_cyc.size() < base + k) fail_timeout(name);
    endtask

    initial begin
        int          a0;
        int          c0;
        logic [31:0] held_inst;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h8000_0000);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        rst = 1'b0;

        // 1: streaming, latency 1
        a0 = acc_log.size();
        c0 = cons_cyc.size();
        wait_cons(3, "t1_stream");
        check("t1_addr0", log_at(a0), 32'h8000_0000);
        check("t1_addr1", log_at(a0 + 1), 32'h8000_0004);
        check("t1_addr2", log_at(a0 + 2), 32'h8000_0008);
        if (cons_cyc.size() >= c0 + 3) begin
            check("t1_period_a", 32'(cons_cyc[c0 + 1] - cons_cyc[c0]), 32'd3);
            check("t1_period_b", 32'(cons_cyc[c0 + 2] - cons_cyc[c0 + 1]), 32'd3);
        end

        // 2: decode backpressure
        tick();
        inst_ready = 1'b0;
        wait_inst_valid("t2_valid");
        held_inst = inst;
        check("t2_held_pc", inst_pc, 32'h8000_000C);
        repeat (5) @(negedge clk);
        check("t2_still_valid", 32'(inst_valid), 32'd1);
        check("t2_inst_stable", inst, held_inst);
        check("t2_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        inst_ready = 1'b1;
        wait_accept("t2_next_req");
        check("t2_next_addr", imem_req_addr, 32'h8000_0010);

        // 3: redirect while waiting on a latency-4 fetch
        mem_lat = 4;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1002;
        tick();
        redirect_valid = 1'b0;
        wait_accept("t3_req");
        check("t3_target_addr", imem_req_addr, 32'h8000_1000);
        mem_lat = 2;
        wait_cons(1, "t3_cons");
        check("t3_cons_pc", last_cons_pc(), 32'h8000_1000);

        // 4a: redirect in the same cycle as the response
        wait_accept("t4a_req");
        @(posedge clk);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_2000;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        wait_accept("t4a_target");
        check("t4a_target_addr", imem_req_addr, 32'h8000_2000);

        // 4b: redirect while holding, with decode ready in the same cycle
        wait_inst_valid("t4b_valid");
        tick();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        wait_accept("t4b_target");
        check("t4b_target_addr", imem_req_addr, 32'h8000_3000);
        wait_cons(1, "t4b_cons");
        check("t4b_cons_pc", last_cons_pc(), 32'h8000_3000);

        // 5: address wrap, then asynchronous reset during a pending fetch
        mem_lat = 4;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_accept("t5_top");
        check("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_accept("t5_wrap");
        check("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("t5_arst_req_addr", imem_req_addr, 32'h8000_0000);
        check("t5_arst_inst_valid", 32'(inst_valid), 32'd0);
        check("t5_arst_inst", inst, 32'd0);
        check("t5_arst_inst_pc", inst_pc, 32'd0);
        #1;
        rst = 1'b0;
        mem_lat = 1;
        wait_accept("t5_restart");
        check("t5_restart_addr", imem_req_addr, 32'h8000_0000);
        wait_cons(1, "t5_cons");
        check("t5_cons_pc", last_cons_pc(), 32'h8000_0000);

        // Random traffic: memory stalls, latencies, backpressure and redirects
        mem_rand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            inst_ready     = ($urandom_range(0, 2) != 0);
            mem_lat        = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = $urandom;
        end
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
